// File: rtl/rnd_harvest_bank.sv
// rnd_harvest_bank: bank of gated entropy sources; one channel per request is synchronised,
// XOR-folded over SAMPLES clocks and returned. Optional whitening LFSR: RND_LFSR_WHITEN_EN.

// Clocked stand-in for the gated oscillator source: advances only while G is low.
module funky_rnd_n #(
   parameter int unsigned  N    = 16,
   parameter logic [N-1:0] STEP = N'(1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         G,
   output logic [N-1:0] R
);
   logic [N-1:0] s_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  s_q <= STEP;
      else if (!G) s_q <= s_q + (STEP | N'(1));
   end

   assign R = s_q ^ (s_q >> 1);
endmodule

module rnd_harvest_bank #(
   parameter int unsigned      CHANNELS  = 40,
   parameter int unsigned      WIDTH     = 16,
   parameter int unsigned      SAMPLES   = 4,
   parameter int unsigned      ADDR_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(16'hB400),
   parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(16'hACE1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] chan,
   output logic              busy,
   output logic              valid,
   output logic [WIDTH-1:0]  data,
   output logic              stuck,
   output logic              err
);
   localparam int unsigned CNT_W = (SAMPLES > 2) ? $clog2(SAMPLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WARM, S_COLLECT, S_DONE} state_e;

   if ((SAMPLES < 2) || (LFSR_SEED == '0) || (LFSR_TAPS == '0)) begin : g_cfg_invalid
      $error("rnd_harvest_bank: SAMPLES must be >= 2 and LFSR taps/seed nonzero");
   end

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] chan_q, chan_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  acc_q, acc_d, acc_next;
   logic [WIDTH-1:0]  prev_q, prev_d;
   logic              cmp_ok_q, cmp_ok_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              stuck_q, stuck_d;
   logic              err_q, err_d;
   logic [WIDTH-1:0]  sync1_q, sync2_q;
   logic [WIDTH-1:0]  src_r [CHANNELS];
   logic              src_gate;
   logic              chan_ok;

   // Sources only run while a word is in flight, so the idle bank stays quiet.
   assign src_gate = (state_q == S_IDLE) || (state_q == S_DONE);

   for (genvar gi = 0; gi < int'(CHANNELS); gi++) begin : rnd_blocks
      funky_rnd_n #(
         .N    (WIDTH),
         .STEP (WIDTH'(32'h9E37_79B9 * (gi + 1)))
      ) rnd_bank (
         .clk   (clk),
         .rst_n (rst_n),
         .G     (src_gate),
         .R     (src_r[gi])
      );
   end

   assign chan_ok  = (32'(chan) < CHANNELS);
   assign acc_next = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]} ^ sync2_q;

`ifdef RND_LFSR_WHITEN_EN
   logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
   assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
`endif

   always_comb begin
      state_d  = state_q;
      chan_d   = chan_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      prev_d   = prev_q;
      cmp_ok_d = cmp_ok_q;
      data_d   = data_q;
      stuck_d  = stuck_q;
      err_d    = 1'b0;
`ifdef RND_LFSR_WHITEN_EN
      lfsr_d   = lfsr_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               if (chan_ok) begin
                  state_d  = S_WARM;
                  chan_d   = chan;
                  cnt_d    = '0;
                  acc_d    = '0;
                  cmp_ok_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_WARM: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_COLLECT;
               cnt_d   = '0;
            end
         end
         S_COLLECT: begin
            acc_d  = acc_next;
            prev_d = sync2_q;
            cnt_d  = cnt_q + CNT_W'(1);
            // The first sample has no predecessor; it only seeds prev.
            if ((cnt_q != '0) && (sync2_q != prev_q)) cmp_ok_d = 1'b0;
`ifdef RND_LFSR_WHITEN_EN
            lfsr_d = lfsr_step;
`endif
            if (cnt_q == CNT_W'(SAMPLES - 1)) begin
               state_d = S_DONE;
               stuck_d = cmp_ok_d;
`ifdef RND_LFSR_WHITEN_EN
               data_d  = acc_next ^ lfsr_step;
`else
               data_d  = acc_next;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         chan_q   <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         prev_q   <= '0;
         cmp_ok_q <= 1'b1;
         data_q   <= '0;
         stuck_q  <= 1'b0;
         err_q    <= 1'b0;
         sync1_q  <= '0;
         sync2_q  <= '0;
`ifdef RND_LFSR_WHITEN_EN
         lfsr_q   <= LFSR_SEED;
`endif
      end else begin
         state_q  <= state_d;
         chan_q   <= chan_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         prev_q   <= prev_d;
         cmp_ok_q <= cmp_ok_d;
         data_q   <= data_d;
         stuck_q  <= stuck_d;
         err_q    <= err_d;
         sync1_q  <= src_r[chan_q];
         sync2_q  <= sync1_q;
`ifdef RND_LFSR_WHITEN_EN
         lfsr_q   <= lfsr_d;
`endif
      end
   end

   assign busy  = (state_q == S_WARM) || (state_q == S_COLLECT);
   assign valid = (state_q == S_DONE);
   assign data  = data_q;
   assign stuck = stuck_q;
   assign err   = err_q;
endmodule

// File: tb/tb_rnd_harvest_bank.sv
// Bench for rnd_harvest_bank: forced source values, behavioural fold/LFSR model, second small build.
`timescale 1ns/1ps
module tb_rnd_harvest_bank;
   localparam int unsigned S = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, busy, valid, stuck, err;
   logic [5:0]  chan;
   logic [15:0] data;
   logic        start6, busy6, valid6, stuck6, err6;
   logic [1:0]  chan6;
   logic [7:0]  data6;

   logic [15:0] frc_v;
   logic [15:0] mdl_lfsr;
   logic [15:0] last_exp;
   logic        last_st;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned chs [6]  = '{0, 1, 3, 5, 17, 39};

   always #5 clk = ~clk;

   rnd_harvest_bank dut (
      .clk(clk), .rst_n(rst_n), .start(start), .chan(chan),
      .busy(busy), .valid(valid), .data(data), .stuck(stuck), .err(err)
   );

   rnd_harvest_bank #(
      .CHANNELS(4), .WIDTH(8), .SAMPLES(2), .LFSR_TAPS(8'hB8), .LFSR_SEED(8'hE1)
   ) dut6 (
      .clk(clk), .rst_n(rst_n), .start(start6), .chan(chan6),
      .busy(busy6), .valid(valid6), .data(data6), .stuck(stuck6), .err(err6)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr16(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   // Word = rotate-left-and-XOR fold of the samples; stuck = all samples equal.
   task automatic model_word(input logic [15:0] smp [S], output logic [15:0] d, output logic st);
      logic [15:0] acc;
      acc = '0;
      st  = 1'b1;
      for (int unsigned j = 0; j < S; j++) begin
         acc = {acc[14:0], acc[15]} ^ smp[j];
         if (smp[j] != smp[0]) st = 1'b0;
         mdl_lfsr = lfsr16(mdl_lfsr);
      end
      d = acc;
`ifdef RND_LFSR_WHITEN_EN
      d = acc ^ mdl_lfsr;
`endif
   endtask

   task automatic src_force(input int unsigned ch);
      case (ch)
         0:  force dut.rnd_blocks[0].rnd_bank.R  = frc_v;
         1:  force dut.rnd_blocks[1].rnd_bank.R  = frc_v;
         3:  force dut.rnd_blocks[3].rnd_bank.R  = frc_v;
         5:  force dut.rnd_blocks[5].rnd_bank.R  = frc_v;
         17: force dut.rnd_blocks[17].rnd_bank.R = frc_v;
         39: force dut.rnd_blocks[39].rnd_bank.R = frc_v;
         default: ;
      endcase
   endtask

   // Called at a negedge; the sync pipeline makes edge E(2+j) fold the value present at edge Ej.
   task automatic do_word(input int unsigned ch, input int unsigned mode, input logic [15:0] cval);
      logic [15:0] vals [S+3];
      logic [15:0] smp [S];
      logic        ph;
      ph = 1'($urandom);
      for (int unsigned k = 0; k < S + 3; k++) begin
         case (mode)
            0:       vals[k] = 16'($urandom);
            1:       vals[k] = cval;
            default: vals[k] = (k[0] ^ ph) ? 16'hAAAA : 16'h5555;
         endcase
      end
      for (int unsigned j = 0; j < S; j++) smp[j] = vals[j+1];
      model_word(smp, last_exp, last_st);
      for (int unsigned k = 0; k < S + 3; k++) begin
         frc_v = vals[k];
         src_force(ch);
         if (k == 0) begin
            start = 1'b1;
            chan  = 6'(ch);
         end else begin
            start = 1'($urandom);
            chan  = 6'($urandom);
         end
         @(negedge clk);
         check_eq($sformatf("busy_ch%0d_e%0d", ch, k), busy, (k < S + 2));
         check_eq($sformatf("valid_ch%0d_e%0d", ch, k), valid, (k == S + 2));
         check_eq($sformatf("err_ch%0d_e%0d", ch, k), err, 0);
      end
      start = 1'b0;
      check_eq($sformatf("data_ch%0d", ch), data, last_exp);
      check_eq($sformatf("stuck_ch%0d", ch), stuck, last_st);
   endtask

   task automatic hold_done(input logic bad);
      start = bad;
      chan  = bad ? 6'(40 + $urandom_range(0, 23)) : 6'($urandom_range(0, 39));
      @(negedge clk);
      check_eq("hold_valid", valid, 1);
      check_eq("hold_busy", busy, 0);
      check_eq("hold_data", data, last_exp);
      check_eq("hold_stuck", stuck, last_st);
      check_eq("hold_err", err, bad);
      start = 1'b0;
   endtask

   initial begin
      logic [7:0] l8;
      logic [7:0] exp6;
      rst_n  = 1'b0;
      start  = 1'b0;
      chan   = '0;
      start6 = 1'b0;
      chan6  = '0;
      frc_v  = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_valid", valid, 0);
      check_eq("rst_data", data, 0);
      check_eq("rst_stuck", stuck, 0);
      check_eq("rst_err", err, 0);
      rst_n    = 1'b1;
      mdl_lfsr = 16'hACE1;
      @(negedge clk);

      do_word(3, 1, 16'h0001);
`ifdef RND_LFSR_WHITEN_EN
      check_eq("first_word_const", data, 16'h1C41);
`else
      check_eq("first_word_const", data, 16'h000F);
`endif
      check_eq("first_word_stuck", stuck, 1);
      hold_done(1'b0);
      hold_done(1'b1);
      hold_done(1'b0);

      do_word(5, 2, 16'h0000);
      check_eq("toggle_stuck", stuck, 0);
      do_word(1, 0, 16'h0000);

      hold_done(1'b1);
      hold_done(1'b0);
      do_word(39, 0, 16'h0000);

      repeat (20) do_word(chs[$urandom_range(0, 5)], $urandom_range(0, 2), 16'($urandom));

      start = 1'b1;
      chan  = 6'd17;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_valid", valid, 0);
      check_eq("midrst_data", data, 0);
      check_eq("midrst_stuck", stuck, 0);
      check_eq("midrst_err", err, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      mdl_lfsr = 16'hACE1;
      @(negedge clk);
      check_eq("postrst_busy", busy, 0);

      start = 1'b1;
      chan  = 6'd63;
      @(negedge clk);
      start = 1'b0;
      check_eq("idle_bad_err", err, 1);
      check_eq("idle_bad_busy", busy, 0);
      check_eq("idle_bad_valid", valid, 0);
      @(negedge clk);
      check_eq("idle_bad_err_clr", err, 0);
      do_word(0, 1, 16'h0001);
`ifdef RND_LFSR_WHITEN_EN
      check_eq("postrst_word", data, 16'h1C41);
`else
      check_eq("postrst_word", data, 16'h000F);
`endif
      do_word(17, 0, 16'h0000);

      exp6 = 8'h81;
`ifdef RND_LFSR_WHITEN_EN
      l8 = 8'hE1;
      repeat (2) l8 = l8[0] ? ((l8 >> 1) ^ 8'hB8) : (l8 >> 1);
      exp6 = exp6 ^ l8;
`endif
      force dut6.rnd_blocks[0].rnd_bank.R = 8'h80;
      start6 = 1'b1;
      chan6  = 2'd0;
      for (int unsigned k = 0; k < 5; k++) begin
         @(negedge clk);
         start6 = 1'b0;
         check_eq($sformatf("s2_busy_e%0d", k), busy6, (k < 4));
         check_eq($sformatf("s2_valid_e%0d", k), valid6, (k == 4));
      end
      check_eq("s2_data", data6, exp6);
      check_eq("s2_stuck", stuck6, 1);
      check_eq("s2_err", err6, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
